// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule for AES-128/192/256. It produces one 32-bit schedule word per
// clock and streams the NR+1 round keys over a valid/ready handshake.
module key_expansion_seq #(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [3:0]        rk_index,
  output logic [127:0]      rk_out,
  output logic              done
);

  if (!(NK == 4 || NK == 6 || NK == 8) || NR != NK + 6) begin : g_bad_nk
    $fatal(1, "key_expansion_seq: NK must be 4, 6 or 8 and NR must equal NK+6");
  end

  localparam logic [5:0] LAST = 6'(4 * (NR + 1) - 1);
  localparam logic [2:0] MLAST = 3'(NK - 1);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] j);
    case (j)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t state, state_nxt;
  logic [NK-1:0][31:0] win;
  logic [2:0][31:0]    cbuf;
  logic [5:0]          i;
  logic [2:0]          m;
  logic [3:0]          r;
  logic [31:0]         temp, wnew;
  logic                gen_en;

  // The fourth word of a key needs the output register free (or being freed this edge).
  assign gen_en = (state == GEN) && ((i[1:0] != 2'd3) || !rk_valid || rk_ready);

  always_comb begin
    temp = win[NK-1];
    if (m == 3'd0)
      temp = sub_word(rot_word(win[NK-1])) ^ {rcon(r), 24'h0};
    else if (NK == 8 && m == 3'd4)
      temp = sub_word(win[NK-1]);
    // For i<NK the window is rotated, so win[0] is key word i.
    wnew = (i < 6'(NK)) ? win[0] : (win[0] ^ temp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GEN;
      GEN:     if (gen_en && i == LAST) state_nxt = DRAIN;
      DRAIN:   if (rk_valid && rk_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '0;
      cbuf     <= '0;
      i        <= '0;
      m        <= '0;
      r        <= '0;
      rk_valid <= 1'b0;
      rk_index <= '0;
      rk_out   <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == DRAIN) && rk_valid && rk_ready;
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
      if (state == IDLE && start) begin
        for (int j = 0; j < NK; j++) win[j] <= key_in[32*(NK-1-j) +: 32];
        i <= '0;
        m <= '0;
        r <= '0;
      end else if (gen_en) begin
        for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
        win[NK-1] <= wnew;
        if (i != LAST) begin
          i <= i + 6'd1;
          if (m == MLAST) begin
            m <= '0;
            r <= r + 4'd1;
          end else begin
            m <= m + 3'd1;
          end
        end
        if (i[1:0] == 2'd3) begin
          rk_out   <= {cbuf[0], cbuf[1], cbuf[2], wnew};
          rk_valid <= 1'b1;
          rk_index <= i[5:2];
        end else begin
          cbuf[i[1:0]] <= wnew;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: three instances (NK=4/6/8) checked against a reference key
// schedule whose S-box is derived from GF(2^8) inversion rather than a stored table.
module tb_key_expansion_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start4 = 0, ready4 = 0, busy4, valid4, done4;
  logic start6 = 0, ready6 = 0, busy6, valid6, done6;
  logic start8 = 0, ready8 = 0, busy8, valid8, done8;
  logic [127:0] key4 = '0;
  logic [191:0] key6 = '0;
  logic [255:0] key8 = '0;
  logic [3:0]   idx4, idx6, idx8;
  logic [127:0] out4, out6, out8;

  key_expansion_seq #(.NK(4)) dut4 (.clk(clk), .rst_n(rst_n), .start(start4), .key_in(key4),
    .busy(busy4), .rk_valid(valid4), .rk_ready(ready4), .rk_index(idx4), .rk_out(out4), .done(done4));
  key_expansion_seq #(.NK(6)) dut6 (.clk(clk), .rst_n(rst_n), .start(start6), .key_in(key6),
    .busy(busy6), .rk_valid(valid6), .rk_ready(ready6), .rk_index(idx6), .rk_out(out6), .done(done6));
  key_expansion_seq #(.NK(8)) dut8 (.clk(clk), .rst_n(rst_n), .start(start8), .key_in(key8),
    .busy(busy8), .rk_valid(valid8), .rk_ready(ready8), .rk_index(idx8), .rk_out(out8), .done(done8));

  int n_checks = 0;
  int n_pass = 0;

  logic [131:0] q4[$], q6[$], q8[$];
  logic [127:0] got4[16], got6[16], got8[16];
  logic [7:0]   sb[256];
  logic [31:0]  wm[60];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [7:0] rc(input int j);
    logic [7:0] v = 8'h01;
    for (int k = 1; k < j; k++) v = v[7] ? ((v << 1) ^ 8'h1b) : (v << 1);
    return v;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Reference schedule over the whole w[] array; key is left-aligned in 256 bits.
  task automatic model(input int nk, input logic [255:0] k);
    for (int n = 0; n < 4 * (nk + 7); n++) begin
      logic [31:0] t;
      if (n < nk) begin
        wm[n] = k[255 - 32*n -: 32];
      end else begin
        t = wm[n-1];
        if (n % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc(n / nk), 24'h0};
        else if (nk == 8 && n % nk == 4) t = subw(t);
        wm[n] = wm[n-nk] ^ t;
      end
    end
  endtask

  task automatic start_key(input int w, input logic [255:0] k, input bit push);
    @(posedge clk); #1;
    case (w)
      4: begin key4 = k[255:128]; start4 = 1'b1; end
      6: begin key6 = k[255:64];  start6 = 1'b1; end
      default: begin key8 = k;    start8 = 1'b1; end
    endcase
    if (push) begin
      model(w, k);
      for (int r = 0; r <= w + 6; r++) begin
        logic [131:0] e;
        e = {4'(r), wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
        case (w)
          4: q4.push_back(e);
          6: q6.push_back(e);
          default: q8.push_back(e);
        endcase
      end
    end
    @(posedge clk); #1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
  endtask

  function automatic logic done_of(input int w);
    case (w)
      4: return done4;
      6: return done6;
      default: return done8;
    endcase
  endfunction

  task automatic set_ready(input int w, input logic v);
    case (w)
      4: ready4 = v;
      6: ready6 = v;
      default: ready8 = v;
    endcase
  endtask

  // Runs until done (bounded); optionally randomises rk_ready and pokes start mid-run.
  task automatic run(input int w, input bit rnd, input bit poke);
    int stall = 0;
    bit seen = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (done_of(w)) begin seen = 1; break; end
      if (poke && c == 6) begin key4 = 128'hffeeddccbbaa99887766554433221100; start4 = 1'b1; end
      if (poke && c == 7) start4 = 1'b0;
      if (rnd) begin
        if (stall > 0) begin
          set_ready(w, 1'b0);
          stall--;
        end else begin
          set_ready(w, 1'b1);
          stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 0;
        end
      end
    end
    check($sformatf("done_seen_nk%0d", w), 132'(seen), 132'd1);
    set_ready(w, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid4 && ready4) begin
        if (q4.size() == 0) check("sb4_unexpected", 132'(q4.size()), 132'd1);
        else begin check("rk4", {idx4, out4}, q4.pop_front()); got4[idx4] = out4; end
      end else if (valid4 && q4.size() != 0) begin
        check("stall4", {idx4, out4}, q4[0]);
      end
      if (done4) check("done_excl4", 132'(valid4), 132'd0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid6 && ready6) begin
        if (q6.size() == 0) check("sb6_unexpected", 132'(q6.size()), 132'd1);
        else begin check("rk6", {idx6, out6}, q6.pop_front()); got6[idx6] = out6; end
      end
      if (done6) check("done_excl6", 132'(valid6), 132'd0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid8 && ready8) begin
        if (q8.size() == 0) check("sb8_unexpected", 132'(q8.size()), 132'd1);
        else begin check("rk8", {idx8, out8}, q8.pop_front()); got8[idx8] = out8; end
      end
      if (done8) check("done_excl8", 132'(valid8), 132'd0);
    end
  end

  initial begin
    logic [255:0] knew;
    bit reached;
    build_sbox();
    repeat (2) @(posedge clk); #1;
    check("reset4", {busy4, valid4, done4, idx4, out4}, 132'd0);
    check("reset68", {busy6, valid6, done6, busy8, valid8, done8, idx6, idx8}, 132'd0);
    rst_n = 1'b1;

    // AES-128 with rk_ready held high: exact latency of the last key and done.
    ready4 = 1'b1;
    start_key(4, K128, 1'b1);
    repeat (44) @(posedge clk); #1;
    check("lat_last4", {valid4, idx4, out4}, {1'b1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});
    check("busy_before_done", 132'(busy4), 132'd1);
    @(posedge clk); #1;
    check("done_pulse", {done4, busy4, valid4}, 3'b100);
    @(posedge clk); #1;
    check("done_clear", 132'(done4), 132'd0);
    check("k128_r0", got4[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("k128_r1", got4[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("q4_empty", 132'(q4.size()), 132'd0);

    // AES-192.
    ready6 = 1'b1;
    start_key(6, K192, 1'b1);
    run(6, 1'b0, 1'b0);
    check("k192_r1", got6[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("k192_r12", got6[12], 128'he98ba06f448c773c8ecc720401002202);
    check("q6_empty", 132'(q6.size()), 132'd0);

    // AES-256, including the mid-key SubWord step.
    ready8 = 1'b1;
    start_key(8, K256, 1'b1);
    run(8, 1'b0, 1'b0);
    check("k256_r1", got8[1], 128'h1f352c073b6108d72d9810a30914dff4);
    check("k256_r2", got8[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    check("k256_r14", got8[14], 128'hfe4890d1e6188d0b046df344706c631e);
    check("q8_empty", 132'(q8.size()), 132'd0);

    // Random backpressure plus a start pulse while busy that must be ignored.
    got4[10] = '0;
    start_key(4, K128, 1'b1);
    run(4, 1'b1, 1'b1);
    check("stall_r10", got4[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("q4_empty_stall", 132'(q4.size()), 132'd0);

    // Asynchronous reset in the middle of round 5, then a fresh key.
    ready4 = 1'b1;
    start_key(4, K128, 1'b1);
    reached = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (valid4 && idx4 == 4'd5) begin reached = 1; break; end
    end
    check("reach_r5", 132'(reached), 132'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {busy4, valid4, done4, idx4, out4}, 132'd0);
    q4.delete();
    repeat (2) @(posedge clk); #1;
    check("held_reset", {busy4, valid4, idx4}, 132'd0);
    rst_n = 1'b1;
    knew = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    start_key(4, knew, 1'b1);
    run(4, 1'b0, 1'b0);
    check("new_key_r0", got4[0], knew[255:128]);
    check("q4_empty_rst", 132'(q4.size()), 132'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
Sequential, parametrised AES key schedule. It supports AES-128, AES-192 and AES-256, selected by NK. It generates one 32-bit schedule word per clock and emits the NR+1 128-bit round keys in order over a valid/ready stream. It sits between the key register and the cipher round datapath, replacing purely combinational per-round expansion. It handles NK>4 word alignment and the NK=8 extra SubWord step.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
NR, NK+6, number of rounds; derived, must not be overridden.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin expansion; sampled only when busy=0.
key_in  input  32*NK  cipher key; word 0 in the most significant 32 bits; sampled with start.
busy  output  1  expansion in progress.
rk_valid  output  1  rk_out/rk_index hold a round key.
rk_ready  input  1  consumer accepts the round key when rk_valid && rk_ready.
rk_index  output  4  round number of rk_out, 0..NR.
rk_out  output  128  round key; word 4*rk_index in the most significant 32 bits.
done  output  1  one-cycle pulse after round key NR is accepted.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy, rk_valid, done = 0; rk_index=0; rk_out=0; word counter, key window and collect buffer cleared. Reset takes effect immediately in any state, including mid-expansion or with rk_valid pending; no partial key is ever emitted afterwards.
- States:
  - IDLE: edge with start=1 latches key_in into an NK-word window, sets word counter i=0 and busy=1, and goes to GEN. start is ignored while busy=1.
  - GEN: one word w[i] per enabled cycle.
  - DRAIN: the last word is generated; waits for final acceptance.
  - Final acceptance then pulses done=1, clears busy, and returns to IDLE.
- Word rule:
  - i<NK: w[i] = key word i.
  - Else temp=w[i-1].
  - If i mod NK = 0: temp = SubWord(RotWord(temp)) xor Rcon[i/NK]. RotWord is a left rotate by one byte. Rcon[j] = {01,02,04,08,10,20,40,80,1b,36}[j-1] in the top byte, 24'h0 below.
  - Else if NK=8 and i mod NK = 4: temp = SubWord(temp).
  - w[i] = w[i-NK] xor temp.
  - The window shifts by one word per generated word.
  - SubWord uses the standard AES S-box, combinational, internal to the block.
- Collection: words with i mod 4 = 0..2 go to a 3-word buffer. The word with i mod 4 = 3 is loaded together with the buffer into rk_out. That same edge sets rk_valid=1 and rk_index=i/4.
- Backpressure: the word with i mod 4 = 3 is generated only if rk_valid=0 or rk_ready=1 in that cycle. Otherwise generation stalls; i, the window and the buffer hold. Words 0..2 of the next key may be generated while rk_valid is pending.
- rk_valid && rk_ready with no new key loaded on the same edge: rk_valid clears. rk_out and rk_index are unchanged while rk_valid=1 && rk_ready=0.
- Latency with rk_ready held 1: start sampled at edge E. Round key k is valid after edge E+4(k+1). Round key NR is valid after edge E+4(NR+1). It is accepted on the next edge, and done=1 for the following cycle. busy=0 from that same edge.
- Total words generated: 4*(NR+1), i.e. 44, 52 or 60. The counter never wraps past the last word. Rcon index never exceeds 10.
- rk_ready without rk_valid is a no-op. done and rk_valid are never high in the same cycle.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk_index0 = key; rk_index1 = a0fafe1788542cb123a339392a6c7605; rk_index10 = d014f9a8c9ee2589e13f0cc8b6630ca6, valid 44 cycles after the start edge; done pulses next cycle.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → rk_index1 = 62f8ead2522c6b7bfe0c91f72402f5a5; rk_index12 = e98ba06f448c773c8ecc720401002202; 13 keys total.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → rk_index1 = 1f352c073b6108d72d9810a30914dff4; rk_index2 = 9ba354118e6925afa51a8b5f2067fcde (exercises the i mod 8 = 4 SubWord step); rk_index14 = fe4890d1e6188d0b046df344706c631e.
- NK=4, rk_ready randomly deasserted for 0..7 cycles → identical key sequence, no skipped or duplicated rk_index, and rk_out stable while stalled.
- start pulsed while busy=1 with a different key → ignored; original sequence completes unchanged.
- rst_n low during round 5 → all outputs 0 immediately. A new start after release with a new key → correct sequence from rk_index 0.
